// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. A round-robin
//   grant picks a requester in IDLE and latches its aluop and operands. The
//   ALU is driven from those registers for one EXEC cycle, and its result is
//   captured. The result is then returned on the owner's response channel
//   with a valid/ready handshake.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready              operation request handshake (N = 0, 1)
//   reqN_aluop/opr_a/opr_b        operation code and operands
//   rspN_valid/ready/res          result handshake and result value
//   alu_opr_a/opr_b/aluop         registered operands to the shared ALU
//   alu_rs1, alu_pc_out           operand A views (rs1 field, AUIPC PC)
//   alu_opr_res                   combinational result from the shared ALU
//   stat_grant0/1                 saturating accept counters
//                                 (only when ALU_SHARE_STATS_EN is defined)
//
// Optional feature macro: ALU_SHARE_STATS_EN
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_aluop,
  input  logic [XLEN-1:0] req0_opr_a,
  input  logic [XLEN-1:0] req0_opr_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_res,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_aluop,
  input  logic [XLEN-1:0] req1_opr_a,
  input  logic [XLEN-1:0] req1_opr_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_res,
  output logic [XLEN-1:0] alu_opr_a,
  output logic [XLEN-1:0] alu_opr_b,
  output logic [OPW-1:0]  alu_aluop,
  output logic [4:0]      alu_rs1,
  output logic [XLEN-1:0] alu_pc_out,
`ifdef ALU_SHARE_STATS_EN
  output logic [15:0]     stat_grant0,
  output logic [15:0]     stat_grant1,
`endif
  input  logic [XLEN-1:0] alu_opr_res
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;      // 0: prefer req0, 1: prefer req1
  logic            owner_q, owner_d;  // requester that owns the current op
  logic [OPW-1:0]  aluop_q, aluop_d;
  logic [XLEN-1:0] opr_a_q, opr_a_d;
  logic [XLEN-1:0] opr_b_q, opr_b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            grant0;
  logic            grant1;
  logic            owner_rsp_ready;

  // Round-robin grant, only offered while idle
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state logic: accept, execute, respond
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    aluop_d = aluop_q;
    opr_a_d = opr_a_q;
    opr_b_d = opr_b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          state_d = ST_EXEC;
          owner_d = grant1;
          aluop_d = grant1 ? req1_aluop : req0_aluop;
          opr_a_d = grant1 ? req1_opr_a : req0_opr_a;
          opr_b_d = grant1 ? req1_opr_b : req0_opr_b;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        res_d   = alu_opr_res;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ready ends the response; the other side is ignored
        if (owner_rsp_ready) begin
          state_d = ST_IDLE;
          ptr_d   = ~owner_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      aluop_q <= {OPW{1'b0}};
      opr_a_q <= {XLEN{1'b0}};
      opr_b_q <= {XLEN{1'b0}};
      res_q   <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      aluop_q <= aluop_d;
      opr_a_q <= opr_a_d;
      opr_b_q <= opr_b_d;
      res_q   <= res_d;
    end
  end

  // Ready is combinational from valid; requesters must not loop it back
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_res   = res_q;
  assign rsp1_res   = res_q;

  // The ALU sees only registered values; they simply hold outside EXEC
  assign alu_opr_a  = opr_a_q;
  assign alu_opr_b  = opr_b_q;
  assign alu_aluop  = aluop_q;
  assign alu_rs1    = opr_a_q[4:0];
  assign alu_pc_out = opr_a_q;

`ifdef ALU_SHARE_STATS_EN
  logic [15:0] stat_grant0_q, stat_grant0_d;
  logic [15:0] stat_grant1_q, stat_grant1_d;

  // Saturating accept counters
  always_comb begin
    stat_grant0_d = stat_grant0_q;
    stat_grant1_d = stat_grant1_q;
    if (grant0 && (stat_grant0_q != 16'hFFFF)) begin
      stat_grant0_d = stat_grant0_q + 16'd1;
    end else begin
      stat_grant0_d = stat_grant0_q;
    end
    if (grant1 && (stat_grant1_q != 16'hFFFF)) begin
      stat_grant1_d = stat_grant1_q + 16'd1;
    end else begin
      stat_grant1_d = stat_grant1_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0_q <= 16'd0;
      stat_grant1_q <= 16'd0;
    end else begin
      stat_grant0_q <= stat_grant0_d;
      stat_grant1_q <= stat_grant1_d;
    end
  end

  assign stat_grant0 = stat_grant0_q;
  assign stat_grant1 = stat_grant1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a behavioural ALU sits on the alu_* port
// set, and a transaction-level model predicts grants, latency and results.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_res, rsp1_res;
  logic [31:0] alu_opr_a, alu_opr_b, alu_pc_out, alu_opr_res;
  logic [3:0]  alu_aluop;
  logic [4:0]  alu_rs1;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0] stat_grant0, stat_grant1;
`endif

  // Requester-side pending requests (held until accepted)
  logic        p_v  [2];
  logic [3:0]  p_op [2];
  logic [31:0] p_a  [2];
  logic [31:0] p_b  [2];

  int pref;        // requester preferred when both are valid
  int n_acc [2];   // saturating accept counts
  int total;
  int bad;

  // Reference ALU: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA
  // 8 OR 9 AND 10 LUI 11 AUIPC 14 RS1; 12, 13, 15 undefined -> 0
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] pc,
                                         input logic [4:0] rs1);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << b[4:0];
      4'd3:    r = {31'd0, ($signed(a) < $signed(b))};
      4'd4:    r = {31'd0, (a < b)};
      4'd5:    r = a ^ b;
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      4'd10:   r = b;
      4'd11:   r = pc + b;
      4'd14:   r = {27'd0, rs1};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign alu_opr_res = alu_fn(alu_aluop, alu_opr_a, alu_opr_b, alu_pc_out, alu_rs1);

  alu_share_arbiter #(.XLEN(32), .OPW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (p_v[0]),
    .req0_ready  (req0_ready),
    .req0_aluop  (p_op[0]),
    .req0_opr_a  (p_a[0]),
    .req0_opr_b  (p_b[0]),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_res    (rsp0_res),
    .req1_valid  (p_v[1]),
    .req1_ready  (req1_ready),
    .req1_aluop  (p_op[1]),
    .req1_opr_a  (p_a[1]),
    .req1_opr_b  (p_b[1]),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_res    (rsp1_res),
    .alu_opr_a   (alu_opr_a),
    .alu_opr_b   (alu_opr_b),
    .alu_aluop   (alu_aluop),
    .alu_rs1     (alu_rs1),
    .alu_pc_out  (alu_pc_out),
`ifdef ALU_SHARE_STATS_EN
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
`endif
    .alu_opr_res (alu_opr_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_rspv0", 32'(rsp0_valid), 32'd0);
    chk("rst_rspv1", 32'(rsp1_valid), 32'd0);
    chk("rst_res0", rsp0_res, 32'd0);
    chk("rst_res1", rsp1_res, 32'd0);
    chk("rst_alu_a", alu_opr_a, 32'd0);
    chk("rst_alu_b", alu_opr_b, 32'd0);
    chk("rst_alu_op", 32'(alu_aluop), 32'd0);
    chk("rst_alu_rs1", 32'(alu_rs1), 32'd0);
    chk("rst_alu_pc", alu_pc_out, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    pref = 0;
    n_acc[0] = 0;
    n_acc[1] = 0;
  endtask

  // One IDLE decision, plus the whole operation if something is granted.
  // Entered and left at posedge+1. keep: requester re-issues the same op.
  // raise_idx: requester that raises its prepared request after the accept.
  task automatic serve(input int stall, input bit keep, input int raise_idx);
    int g;
    logic [3:0]  eo;
    logic [31:0] ea, eb, er;
    @(negedge clk);
    if (!p_v[0] && !p_v[1]) begin
      chk("idle_rdy0", 32'(req0_ready), 32'd0);
      chk("idle_rdy1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      return;
    end
    g = (p_v[0] && p_v[1]) ? pref : (p_v[0] ? 0 : 1);
    chk("grant_rdy0", 32'(req0_ready), 32'(g == 0));
    chk("grant_rdy1", 32'(req1_ready), 32'(g == 1));
    eo = p_op[g];
    ea = p_a[g];
    eb = p_b[g];
    er = alu_fn(eo, ea, eb, ea, ea[4:0]);
    @(posedge clk);
    #1;
    if (!keep) p_v[g] = 1'b0;
    if (raise_idx >= 0) p_v[raise_idx] = 1'b1;
    if (n_acc[g] < 65535) n_acc[g]++;
    // rsp_ready while nothing is valid must have no effect
    rsp0_ready = 1'($urandom_range(0, 1));
    rsp1_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("exec_rdy0", 32'(req0_ready), 32'd0);
    chk("exec_rdy1", 32'(req1_ready), 32'd0);
    chk("exec_rspv0", 32'(rsp0_valid), 32'd0);
    chk("exec_rspv1", 32'(rsp1_valid), 32'd0);
    chk("exec_aluop", 32'(alu_aluop), {28'd0, eo});
    chk("exec_opr_a", alu_opr_a, ea);
    chk("exec_opr_b", alu_opr_b, eb);
    chk("exec_pc_out", alu_pc_out, ea);
    chk("exec_rs1", 32'(alu_rs1), {27'd0, ea[4:0]});
    @(posedge clk);
    #1;
    for (int s = 0; s <= stall; s++) begin
      if (g == 0) begin
        rsp0_ready = (s == stall);
        rsp1_ready = 1'($urandom_range(0, 1));
      end else begin
        rsp1_ready = (s == stall);
        rsp0_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("resp_v0", 32'(rsp0_valid), 32'(g == 0));
      chk("resp_v1", 32'(rsp1_valid), 32'(g == 1));
      chk("resp_res", (g == 0) ? rsp0_res : rsp1_res, er);
      chk("resp_rdy0", 32'(req0_ready), 32'd0);
      chk("resp_rdy1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    pref = 1 - g;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0;
      set_req(i, 4'd0, 32'd0, 32'd0);
    end

    // Reset values
    do_reset();

    // req0 ADD 5+7 = 12
    set_req(0, 4'd0, 32'd5, 32'd7);
    p_v[0] = 1'b1;
    serve(0, 1'b0, -1);

    // Both valid continuously from reset: SUB and XOR alternate
    do_reset();
    set_req(0, 4'd1, 32'd10, 32'd3);
    set_req(1, 4'd5, 32'h0000_00F0, 32'h0000_00FF);
    p_v[0] = 1'b1;
    p_v[1] = 1'b1;
    for (int k = 0; k < 4; k++) serve(0, 1'b1, -1);
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;

    // req1 SLL 1<<31 stalled 5 cycles; req0 AUIPC waits behind it
    set_req(1, 4'd2, 32'd1, 32'd31);
    set_req(0, 4'd11, 32'h0000_1000, 32'h0000_0020);
    p_v[1] = 1'b1;
    serve(5, 1'b0, 0);
    serve(0, 1'b0, -1);
    // Undefined aluop passes through and returns 0
    set_req(1, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    p_v[1] = 1'b1;
    serve(1, 1'b0, -1);

    // Reset during EXEC: no response, pointer back to req0
    set_req(0, 4'd0, 32'd1, 32'd2);
    p_v[0] = 1'b1;
    serve(0, 1'b0, -1);
    p_v[0] = 1'b1;
    @(negedge clk);
    chk("pre_abort_rdy0", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    p_v[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    chk("abort_rspv0", 32'(rsp0_valid), 32'd0);
    @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    pref = 0;
    n_acc[0] = 0;
    n_acc[1] = 0;
    set_req(0, 4'd8, 32'hF000_0000, 32'h0000_000F);
    set_req(1, 4'd9, 32'hFFFF_0000, 32'h00FF_FF00);
    p_v[0] = 1'b1;
    p_v[1] = 1'b1;
    serve(0, 1'b0, -1);
    serve(0, 1'b0, -1);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_v[i] && ($urandom_range(0, 2) != 0)) begin
          set_req(i, 4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
          p_v[i] = 1'b1;
        end
      end
      serve($urandom_range(0, 3), 1'b0, -1);
    end
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    serve(0, 1'b0, -1);

`ifdef ALU_SHARE_STATS_EN
    chk("stat0_random", 32'(stat_grant0), 32'(n_acc[0]));
    chk("stat1_random", 32'(stat_grant1), 32'(n_acc[1]));
    do_reset();
    chk("stat0_reset", 32'(stat_grant0), 32'd0);
    set_req(0, 4'd0, 32'd3, 32'd4);
    set_req(1, 4'd1, 32'd9, 32'd4);
    for (int k = 0; k < 3; k++) begin
      p_v[0] = 1'b1;
      serve(0, 1'b0, -1);
    end
    p_v[1] = 1'b1;
    serve(0, 1'b0, -1);
    chk("stat0_three", 32'(stat_grant0), 32'd3);
    chk("stat1_one", 32'(stat_grant1), 32'd1);
    force dut.stat_grant0_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.stat_grant0_q;
    n_acc[0] = 65534;
    for (int k = 0; k < 3; k++) begin
      p_v[0] = 1'b1;
      serve(0, 1'b0, -1);
    end
    chk("stat0_sat", 32'(stat_grant0), 32'h0000_FFFF);
    chk("stat0_model", 32'(stat_grant0), 32'(n_acc[0]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the team's combinational 32-bit ALU between two requesters, for example the main execute path (req0) and an address/auxiliary unit (req1).
- Arbitrates round-robin and latches the winner's operands into registers.
- Drives the ALU from those registers, captures its result, and returns it on the winner's response channel with a valid/ready handshake.
- Sits between the requesters and the ALU instance; the ALU itself stays purely combinational.

Parameters:
- XLEN, 32, operand/result width; must match the ALU instance.
- OPW, 4, aluop width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_aluop  in  OPW  operation code, same encoding as the ALU
- req0_opr_a  in  XLEN  operand A
- req0_opr_b  in  XLEN  operand B
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes the result
- rsp0_res  out  XLEN  result for requester 0
- req1_valid, req1_ready, req1_aluop, req1_opr_a, req1_opr_b, rsp1_valid, rsp1_ready, rsp1_res: identical to the requester 0 set, for requester 1
- alu_opr_a  out  XLEN  to ALU opr_a
- alu_opr_b  out  XLEN  to ALU opr_b
- alu_aluop  out  OPW  to ALU aluop
- alu_rs1  out  5  to ALU rs1; equals latched opr_a[4:0]
- alu_pc_out  out  XLEN  to ALU pc_out; equals latched opr_a (AUIPC supplies the PC as operand A)
- alu_opr_res  in  XLEN  from ALU opr_res

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, round-robin pointer=0 (req0 preferred next).
  - Operand, aluop and result registers are 0.
  - All ready/valid outputs are 0; rsp*_res=0; all alu_* outputs are 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the one the pointer prefers.
  - reqN_ready = (state==IDLE) & grantN. This is combinational from valid; requesters must not make valid depend on ready.
  - On accept: latch aluop/opr_a/opr_b, record the owner, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (exactly one cycle):
  - alu_* outputs are driven from the latched registers; they are registered values and stable for the whole cycle.
  - Capture alu_opr_res into the result register at the clock edge, then go to RESP.
- RESP:
  - rspN_valid=1 for the owner only; rspN_res = result register, held stable while valid and not ready.
  - When rspN_ready is seen: go to IDLE and set the pointer to prefer the non-owner.
  - No request is accepted while in EXEC or RESP; both readys are 0.
- Latency: accept at edge N, rsp_valid high from cycle N+2. Minimum 3 cycles per operation.
- alu_* outputs keep their last latched value outside EXEC; the ALU is combinational, so this is harmless.
- Undefined aluops (1100, 1101, 1111) are passed through unchanged; the result is whatever the ALU returns (0).
- Only one request can be accepted per IDLE cycle; a pending request stays pending because its ready is 0.
- rsp_ready asserted by a non-owner is ignored. rsp_ready asserted while rsp_valid is 0 has no effect.
- Asserting rst_n low mid-operation (EXEC or RESP) aborts the operation: no response is issued and the state returns to IDLE with reset values.

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- When defined:
  - Adds output ports stat_grant0 and stat_grant1, each 16 bits.
  - Each counts accepts for its requester, saturating at 16'hFFFF.
  - Both reset to 0 on rst_n.
- When not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 ADD (aluop 0000, a=5, b=7) with rsp0_ready=1 -> req0_ready pulse on the accept cycle; rsp0_valid 2 cycles later with rsp0_res=12; rsp1_valid stays 0.
- req0 and req1 both valid, continuously, from reset: req0 SUB(10,3) and req1 XOR(0xF0,0xFF) -> grant order req0, req1, req0, req1; results 7 and 0x0F alternate; each accept is 3 cycles after the previous one.
- req1 SLL (a=1, b=31) with rsp1_ready held 0 for 5 cycles -> rsp1_valid and rsp1_res=0x80000000 stay stable; req0_ready stays 0 throughout; after rsp1_ready, req0 is accepted the next cycle.
- req0 AUIPC (aluop 1011, a=0x1000, b=0x20) -> alu_pc_out=0x1000 during EXEC, rsp0_res=0x1020. req1 aluop 1111 -> rsp1_res=0.
- Assert rst_n low during EXEC of req0 -> no rsp0_valid; all outputs return to reset values; the pointer resets so a subsequent simultaneous request grants req0 first.
- With ALU_SHARE_STATS_EN: 3 accepts for req0 and 1 for req1 -> stat_grant0=3, stat_grant1=1. Preloading stat_grant0 near saturation (force) -> it holds at 16'hFFFF.
